// File: rtl/fp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared widths, constants and types for the FP result packer
//               (custom 32-bit AU format -> IEEE-754 single precision).
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

   // Arithmetic-unit result format: sign[31], exponent[30:25], fraction[24:0]
   localparam int EXP_W      = 6;
   localparam int FRAC_W     = 25;
   localparam int BIAS       = 31;

   // IEEE-754 single precision
   localparam int IEEE_EXP_W = 8;
   localparam int MANT_W     = 23;
   localparam int IEEE_BIAS  = 127;

   // Rebiasing offset applied to normal exponents (31 -> 127)
   localparam logic [IEEE_EXP_W-1:0] EXP_OFFSET   = IEEE_EXP_W'(IEEE_BIAS - BIAS);
   localparam logic [IEEE_EXP_W-1:0] IEEE_EXP_MAX = '1;
   localparam logic [31:0]           QNAN         = 32'h7FC0_0000;

   // Status bit indices
   localparam int ST_EXACT        = 0;
   localparam int ST_OVERFLOW     = 1;
   localparam int ST_UNDERFLOW    = 2;
   localparam int ST_INEXACT      = 3;
   localparam int ST_CONV_INEXACT = 4;
   localparam int STATUS_W        = 5;

   // Output buffer
   localparam int FIFO_DEPTH = 4;
   localparam int ENTRY_W    = 32 + STATUS_W;

   // Class of the decoded input value
   typedef enum logic [1:0] {
      K_ZERO   = 2'd0,
      K_NORMAL = 2'd1,
      K_INF    = 2'd2,
      K_NAN    = 2'd3
   } kind_t;

   // Stage-1 result: decoded and rounded, not yet packed
   typedef struct packed {
      kind_t                 kind;
      logic                  sign;
      logic [IEEE_EXP_W-1:0] exp;
      logic [MANT_W-1:0]     mant;
      logic [STATUS_W-1:0]   status;
   } dec_t;

endpackage
`default_nettype wire

// File: rtl/fp_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fp_fifo
// Description : Small synchronous FIFO with head-of-queue read and occupancy
//               count. Pointers wrap naturally (DEPTH must be a power of 2).
// Revision    : 1.0 - initial release
// ============================================================================
module fp_fifo
   import fp_pkg::*;
#(
   parameter  int WIDTH = ENTRY_W,
   parameter  int DEPTH = FIFO_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is allowed only when a pop frees a slot this edge
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

   // Storage array; contents are meaningless while count is zero
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/fp_result_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fp_result_packer
// Description : Converts arithmetic-unit results (6-bit exponent, 25-bit
//               fraction) into IEEE-754 single precision through a 2-stage
//               pipeline (decode+round, pack) feeding a 4-entry output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_result_packer
   import fp_pkg::*;
(
   input  logic        clock_100kHz,
   input  logic        reset,
   input  logic [31:0] res_in,
   input  logic [3:0]  status_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_status,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  count,
   output logic        drop_err
);

   logic                  sign;
   logic [EXP_W-1:0]      exp_f;
   logic [FRAC_W-1:0]     frac_f;
   logic                  lsb;
   logic                  guard;
   logic                  sticky;
   logic                  round_up;
   logic [MANT_W:0]       mant_rnd;
   logic                  accept;
   logic                  s1_valid;
   logic                  s2_valid;
   dec_t                  dec;
   dec_t                  s1_q;
   logic [31:0]           word;
   logic [ENTRY_W-1:0]    s2_q;
   logic [ENTRY_W-1:0]    head;
   logic [2:0]            occupancy;

   assign sign   = res_in[31];
   assign exp_f  = res_in[30:25];
   assign frac_f = res_in[FRAC_W-1:0];

   // Round-to-nearest-even from 25 to 23 fraction bits; bit MANT_W is carry-out
   assign lsb      = frac_f[2];
   assign guard    = frac_f[1];
   assign sticky   = frac_f[0];
   assign round_up = guard & (sticky | lsb);
   assign mant_rnd = {1'b0, frac_f[FRAC_W-1:2]} + {{MANT_W{1'b0}}, round_up};

   // Admission is based on registered occupancy only, so a pop this cycle does
   // not open a slot until the next one
   assign occupancy = count + {2'b00, s1_valid} + {2'b00, s2_valid};
   assign in_ready  = ~reset & (occupancy < 3'd4);
   assign accept    = in_valid & in_ready;

   // Stage 1: classify the input and round normal values
   always_comb begin
      dec.kind   = K_NORMAL;
      dec.sign   = sign;
      // Carry-out leaves mant_rnd[MANT_W-1:0] at zero and bumps the exponent
      dec.exp    = {2'b00, exp_f} + EXP_OFFSET + {7'd0, mant_rnd[MANT_W]};
      dec.mant   = mant_rnd[MANT_W-1:0];
      dec.status = '0;
      dec.status[ST_INEXACT:ST_EXACT] = status_in;
      dec.status[ST_CONV_INEXACT]     = guard | sticky;
      if (exp_f == '0) begin
         dec.kind = K_ZERO;
         dec.exp  = '0;
         dec.mant = '0;
         dec.status[ST_CONV_INEXACT] = |frac_f;
      end else if (exp_f == '1) begin
         dec.kind = (frac_f == '0) ? K_INF : K_NAN;
         dec.exp  = '0;
         dec.mant = '0;
         dec.status[ST_CONV_INEXACT] = 1'b0;
      end
   end

   // Stage 2: pack the decoded fields into the IEEE word
   always_comb begin
      word = {s1_q.sign, s1_q.exp, s1_q.mant};
      case (s1_q.kind)
         K_ZERO:  word = {s1_q.sign, 31'h0};
         K_INF:   word = {s1_q.sign, IEEE_EXP_MAX, {MANT_W{1'b0}}};
         K_NAN:   word = QNAN;
         default: word = {s1_q.sign, s1_q.exp, s1_q.mant};
      endcase
   end

   // Pipeline valid bits and sticky drop flag; cleared asynchronously by reset
   always_ff @(posedge clock_100kHz or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         drop_err <= 1'b0;
      end else begin
         s1_valid <= accept;
         s2_valid <= s1_valid;
         if (in_valid && !in_ready) drop_err <= 1'b1;
      end
   end

   // Pipeline payload registers; only meaningful when the matching valid is set
   always_ff @(posedge clock_100kHz) begin
      if (accept)   s1_q <= dec;
      if (s1_valid) s2_q <= {s1_q.status, word};
   end

   fp_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clock_100kHz),
      .rst       (reset),
      .push      (s2_valid),
      .push_data (s2_q),
      .pop       (out_valid & out_ready),
      .head      (head),
      .count     (count)
   );

   // Head is forced to zero when empty so stale storage never reaches the port
   assign out_valid  = (count != 3'd0);
   assign out_data   = out_valid ? head[31:0]        : 32'h0;
   assign out_status = out_valid ? head[ENTRY_W-1:32] : 5'h0;

endmodule
`default_nettype wire

// File: tb/tb_fp_result_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fp_result_packer
// Description : Self-checking bench for fp_result_packer with directed corner
//               cases and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_result_packer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] res_in = '0;
   logic [3:0]  status_in = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic [4:0]  out_status;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [2:0]  count;
   logic        drop_err;

   int n_vec = 0;
   int n_err = 0;

   logic [36:0] exp_q[$];
   logic [36:0] got_q[$];

   always #5 clk = ~clk;

   fp_result_packer dut (
      .clock_100kHz (clk),
      .reset        (reset),
      .res_in       (res_in),
      .status_in    (status_in),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_status   (out_status),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .count        (count),
      .drop_err     (drop_err)
   );

   // Expected {conv_inexact, status, ieee_word} from the numeric definition
   function automatic logic [36:0] ref_model(input logic [31:0] r, input logic [3:0] st);
      int unsigned e, f, q, rem, ie;
      logic [31:0] d;
      logic        cx;
      e = 32'(r[30:25]);
      f = 32'(r[24:0]);
      if (e == 0) begin
         d  = {r[31], 31'h0};
         cx = (f != 0);
      end else if (e == 63) begin
         d  = (f == 0) ? {r[31], 8'hFF, 23'h0} : 32'h7FC00000;
         cx = 1'b0;
      end else begin
         q   = f / 4;
         rem = f % 4;
         if (rem > 2 || (rem == 2 && (q % 2) == 1)) q = q + 1;
         ie = e - 31 + 127;
         if (q == (1 << 23)) begin
            q  = 0;
            ie = ie + 1;
         end
         d  = {r[31], 8'(ie), 23'(q)};
         cx = (rem != 0);
      end
      return {cx, st, d};
   endfunction

   // Random input biased towards zero/inf/NaN and rounding corners
   function automatic logic [31:0] rand_word();
      int unsigned sel;
      logic [5:0]  e;
      logic [24:0] f;
      sel = $urandom_range(0, 9);
      e   = 6'($urandom_range(1, 62));
      f   = 25'($urandom);
      if (sel == 0) e = 6'd0;
      if (sel == 1) e = 6'd63;
      if (sel == 1 && $urandom_range(0, 1) == 0) f = '0;
      if (sel == 2) f = '1;
      if (sel == 3) f[2:0] = 3'($urandom_range(1, 3) * 2);
      if (sel == 4) begin
         e = 6'd62;
         f = '1;
      end
      return {1'($urandom), e, f};
   endfunction

   // One clock: apply inputs, record handshakes just before the edge
   task automatic drive_cycle(input logic v, input logic [31:0] d, input logic [3:0] s,
                              input logic rdy, output logic acc);
      in_valid  = v;
      res_in    = d;
      status_in = s;
      out_ready = rdy;
      #1;
      acc = v && in_ready;
      if (acc) exp_q.push_back(ref_model(d, s));
      if (out_valid && rdy) got_q.push_back({out_status, out_data});
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max_cycles);
      logic acc;
      for (int i = 0; i < max_cycles && got_q.size() < exp_q.size(); i++)
         drive_cycle(1'b0, 32'h0, 4'h0, 1'b1, acc);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_vec++; if (drop_err !== 1'b0) begin n_err++; $display("FAIL reset_drop_err: got %b want 0", drop_err); end
      n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_vec++; if (out_status !== 5'h0) begin n_err++; $display("FAIL reset_out_status: got %h want 0", out_status); end
      reset = 1'b0;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
      @(posedge clk);
      #1;
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL release_count: got %0d want 0", count); end
   endtask

   task automatic test_latency();
      logic acc;
      exp_q.delete();
      got_q.delete();
      drive_cycle(1'b1, 32'h3E000000, 4'b0001, 1'b0, acc);
      n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL lat_accept: got %b want 1", acc); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_n1_valid: got %b want 0", out_valid); end
      drive_cycle(1'b1, 32'h40000000, 4'b0001, 1'b0, acc);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_n2_valid_early: got %b want 0", out_valid); end
      drive_cycle(1'b0, 32'h0, 4'h0, 1'b0, acc);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lat_n2_valid: got %b want 1", out_valid); end
      n_vec++; if (out_data !== 32'h3F800000) begin n_err++; $display("FAIL lat_head_data: got %h want 3f800000", out_data); end
      n_vec++; if (out_status !== 5'b00001) begin n_err++; $display("FAIL lat_head_status: got %b want 00001", out_status); end
      drain(10);
      n_vec++;
      if (got_q.size() != 2) begin
         n_err++; $display("FAIL lat_drain_count: got %0d want 2", got_q.size());
      end else begin
         if (got_q[0] !== {5'b00001, 32'h3F800000}) begin n_err++; $display("FAIL lat_word0: got %h want %h", got_q[0], {5'b00001, 32'h3F800000}); end
         n_vec++;
         if (got_q[1] !== {5'b00001, 32'h40000000}) begin n_err++; $display("FAIL lat_word1: got %h want %h", got_q[1], {5'b00001, 32'h40000000}); end
      end
   endtask

   task automatic test_corner_values();
      logic [31:0] vin  [6] = '{32'h3E000002, 32'h3E000006, 32'h3FFFFFFF,
                                32'h80000000, 32'h7E000000, 32'h7E000001};
      logic [31:0] vout [6] = '{32'h3F800000, 32'h3F800002, 32'h40000000,
                                32'h80000000, 32'h7F800000, 32'h7FC00000};
      logic        vcx  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [3:0]  st   [6];
      logic        acc;
      exp_q.delete();
      got_q.delete();
      for (int i = 0; i < 6; i++) begin
         st[i] = 4'($urandom);
         acc   = 1'b0;
         for (int t = 0; t < 8 && !acc; t++) drive_cycle(1'b1, vin[i], st[i], 1'b1, acc);
      end
      drain(20);
      n_vec++;
      if (got_q.size() != 6) begin
         n_err++; $display("FAIL corner_count: got %0d want 6", got_q.size());
      end
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== {vcx[i], st[i], vout[i]})
            begin n_err++; $display("FAIL corner_%0d in=%h: got %h want %h", i, vin[i], got_q[i], {vcx[i], st[i], vout[i]}); end
      end
   endtask

   task automatic test_back_to_back();
      logic acc;
      int   n_acc = 0;
      exp_q.delete();
      got_q.delete();
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b1, rand_word(), 4'($urandom), 1'b0, acc);
         if (acc) n_acc++;
      end
      n_vec++; if (n_acc != 4) begin n_err++; $display("FAIL bp_accepted: got %0d want 4", n_acc); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      n_vec++; if (drop_err !== 1'b1) begin n_err++; $display("FAIL bp_drop_err: got %b want 1", drop_err); end
      drive_cycle(1'b0, 32'h0, 4'h0, 1'b0, acc);
      n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL bp_count_full: got %0d want 4", count); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
      n_vec++;
      if ({out_status, out_data} !== exp_q[0]) begin n_err++; $display("FAIL bp_head_hold: got %h want %h", {out_status, out_data}, exp_q[0]); end
      drive_cycle(1'b0, 32'h0, 4'h0, 1'b0, acc);
      n_vec++;
      if ({out_status, out_data} !== exp_q[0]) begin n_err++; $display("FAIL bp_head_stable: got %h want %h", {out_status, out_data}, exp_q[0]); end
      drain(20);
      n_vec++;
      if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp_drain_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_word_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL bp_count_empty: got %0d want 0", count); end
   endtask

   task automatic test_random();
      logic        acc, v, rdy, exp_rdy, pop;
      logic [31:0] w;
      logic [3:0]  st;
      int          mcount = 0;
      int          p1 = 0;
      int          p2 = 0;
      exp_q.delete();
      got_q.delete();
      for (int c = 0; c < 400; c++) begin
         v       = ($urandom_range(0, 3) != 0);
         rdy     = ($urandom_range(0, 2) != 0);
         w       = rand_word();
         st      = 4'($urandom);
         exp_rdy = ((mcount + p1 + p2) < 4);
         n_vec++; if (count !== 3'(mcount)) begin n_err++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", c, count, mcount); end
         n_vec++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_in_ready cyc %0d: got %b want %b", c, in_ready, exp_rdy); end
         n_vec++; if (out_valid !== (mcount != 0)) begin n_err++; $display("FAIL rnd_out_valid cyc %0d: got %b want %b", c, out_valid, (mcount != 0)); end
         pop = (mcount != 0) && rdy;
         drive_cycle(v, w, st, rdy, acc);
         mcount = mcount + p2 - (pop ? 1 : 0);
         p2     = p1;
         p1     = (v && exp_rdy) ? 1 : 0;
      end
      drain(40);
      n_vec++;
      if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd_drain_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_word_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_midflight();
      logic acc;
      exp_q.delete();
      got_q.delete();
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, rand_word(), 4'($urandom), 1'b0, acc);
      in_valid = 1'b0;
      n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL mid_count_pre: got %0d want 2", count); end
      #2;
      reset = 1'b1;
      #1;
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", count); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
      n_vec++; if (drop_err !== 1'b0) begin n_err++; $display("FAIL mid_drop_err: got %b want 0", drop_err); end
      n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL mid_out_data: got %h want 0", out_data); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      got_q.delete();
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b0, 32'h0, 4'h0, 1'b1, acc);
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale_valid cyc %0d: got %b want 0", i, out_valid); end
         n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL mid_stale_count cyc %0d: got %0d want 0", i, count); end
      end
      n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL mid_stale_words: got %0d want 0", got_q.size()); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_corner_values();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/fp_result_packer.md
FP_RESULT_PACKER -- requirements
Module: fp_result_packer

Interface
REQ-001 SHALL have port clock_100kHz  input  1  single system clock; all state on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port res_in  input  32  arithmetic-unit result: sign[31], exponent[30:25] (bias 31), fraction[24:0].
REQ-004 SHALL have port status_in  input  4  arithmetic-unit status: [0] exact, [1] overflow, [2] underflow, [3] inexact.
REQ-005 SHALL have port in_valid  input  1  res_in/status_in valid this cycle.
REQ-006 SHALL have port in_ready  output  1  packer accepts a word this cycle.
REQ-007 SHALL have port out_data  output  32  IEEE-754 single-precision word at FIFO head.
REQ-008 SHALL have port out_status  output  5  status_in[3:0] passthrough; [4] conversion-inexact.
REQ-009 SHALL have port out_valid  output  1  FIFO head valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes head this cycle.
REQ-011 SHALL have port count  output  3  entries in FIFO, 0..4.
REQ-012 SHALL have port drop_err  output  1  sticky: in_valid seen while in_ready low.

Function
REQ-013 SHALL accept a word when in_valid and in_ready are both high on a rising edge; otherwise ignore inputs.
REQ-014 SHALL convert in a 2-stage pipeline: stage 1 decode + round, stage 2 pack; result is written into FIFO at end of stage 2.
REQ-015 SHALL present an accepted word at out_valid 2 cycles after acceptance when FIFO was empty (accept edge N, out_valid high after edge N+2).
REQ-016 SHALL decode exponent field 0 as signed zero: out {sign, 31'b0}, fraction discarded, out_status[4]=1 if fraction nonzero.
REQ-017 SHALL decode exponent 63 with fraction 0 as infinity {sign, 0xFF, 23'b0}; exponent 63 with fraction nonzero as quiet NaN 0x7FC00000.
REQ-018 SHALL map normal exponent e (1..62) to IEEE exponent e+96.
REQ-019 SHALL round fraction 25->23 bits round-to-nearest-even: lsb=frac[2], guard=frac[1], sticky=frac[0]; round up if guard & (sticky | lsb).
REQ-020 SHALL propagate rounding carry-out into exponent (fraction becomes 0, exponent +1); no IEEE overflow is reachable.
REQ-021 SHALL set out_status[4] when guard|sticky is nonzero on a normal input.
REQ-022 SHALL hold a 4-entry FIFO; pop when out_valid and out_ready both high; out_data/out_status stable while out_valid high and out_ready low.
REQ-023 SHALL drive in_ready = (FIFO count + pipeline stages occupied) < 4, computed from registered state only; a pop does not raise in_ready in the same cycle.
REQ-024 SHALL handle simultaneous push-into-FIFO and pop: count unchanged, order preserved.
REQ-025 SHALL set drop_err on any edge with in_valid high and in_ready low; drop_err cleared only by reset.
REQ-026 SHALL maintain FIFO pointers with 2-bit wrap-around.

Reset
REQ-027 SHALL, on reset assertion at any time including mid-pipeline, asynchronously clear pipeline valids, FIFO pointers, count, drop_err; out_valid=0, in_ready=0 while reset high, in_ready=1 first cycle after release; out_data/out_status=0.
REQ-028 SHALL discard in-flight words on reset; no partial word emitted after release.

Structure
REQ-029 SHALL take widths and constants from shared package fp_pkg: EXP_W=6, FRAC_W=25, BIAS=31, IEEE_BIAS=127, status bit indices, NaN constant, FIFO depth 4.
REQ-030 SHALL instantiate one sub-module fp_fifo (4 x 37 bits, push/pop/count) for buffering.

Verification
REQ-031 SHALL test res_in 0x3E000000 (1.0) then 0x40000000 (2.0) -> out_data 0x3F800000, 0x40000000 in order, out_status[4]=0, 2-cycle latency.
REQ-032 SHALL test 0x3E000002 -> 0x3F800000 (tie, even) with out_status[4]=1; 0x3E000006 -> 0x3F800002 with out_status[4]=1; 0x3FFFFFFF -> 0x40000000.
REQ-033 SHALL test 0x80000000 -> 0x80000000; 0x7E000000 -> 0x7F800000; 0x7E000001 -> 0x7FC00000.
REQ-034 SHALL test out_ready=0 with 5 back-to-back in_valid -> 4 accepted, in_ready low, drop_err=1, count=4; then out_ready=1 -> 4 words drained in order.
REQ-035 SHALL test reset pulse with 2 words in pipeline and 2 in FIFO -> count=0, out_valid=0, drop_err=0, no stale output after release.
